// File: rtl/w0rm_core_regfile_write_arbiter_pkg.sv
// Shared core package w0rm_core_pkg: register-file sizing defaults,
// write-back requester indices and the constant log2 helper used to size
// address fields.
package w0rm_core_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 32;
    localparam int NUM_REGISTERS_DEFAULT = 16;

    // Write-back requester indices (index 0 has the highest fixed priority)
    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LOAD = 1;

    // ceil(log2(value)), never smaller than 1 so it can size a vector
    function automatic int clog2_f(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/w0rm_core_regfile_write_arbiter_if.sv
// Write-back request bus: one valid/addr/data lane per requester and the
// arbiter's one-hot ready vector back to the requesters.
interface w0rm_core_regfile_write_arbiter_if
    import w0rm_core_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int REG_ADDR_BITS  = 4,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT
);

    logic [NUM_REQUESTERS-1:0]               req_valid;
    logic [NUM_REQUESTERS-1:0]               req_ready;
    logic [NUM_REQUESTERS*REG_ADDR_BITS-1:0] req_addr;
    logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/w0rm_core_regfile_write_arbiter_priority_picker.sv
// Priority picker: scans the request vector starting at start_idx, wrapping
// modulo NUM_REQ, and returns the first requester found as a one-hot grant
// plus its encoded index.
module w0rm_core_priority_picker
    import w0rm_core_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [IDX_BITS-1:0] start_idx,
    output logic [NUM_REQ-1:0]  grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_any
);

    // First asserted request at or after start_idx (with wrap) wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req[(int'(start_idx) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant[(int'(start_idx) + k) % NUM_REQ] = 1'b1;
                grant_idx = IDX_BITS'((int'(start_idx) + k) % NUM_REQ);
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/w0rm_core_regfile_write_arbiter.sv
// Register-file write arbiter: grants one write-back requester per cycle,
// registers the winner onto the register-file write port and keeps the
// pending-write scoreboard used by the issue stage.
// Optional build macro W0RM_RF_ARB_ROUND_ROBIN_EN selects rotating priority
// (default build: fixed priority, requester 0 highest, no pointer register).
module w0rm_core_regfile_write_arbiter
    import w0rm_core_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int NUM_REGISTERS  = NUM_REGISTERS_DEFAULT,
    parameter int NUM_REQUESTERS = 2,
    localparam int REG_ADDR_BITS = clog2_f(NUM_REGISTERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    w0rm_core_regfile_write_arbiter_if.slave wb,
    input  logic                     reserve_valid,
    input  logic [REG_ADDR_BITS-1:0] reserve_addr,
    output logic                     reserve_stall,
    output logic [NUM_REGISTERS-1:0] pending_mask,
    output logic [REG_ADDR_BITS-1:0] port_write_addr,
    output logic                     port_write_enable,
    output logic [DATA_WIDTH-1:0]    port_write_data
);

    localparam int IDX_BITS = clog2_f(NUM_REQUESTERS);

    logic [IDX_BITS-1:0]       start_idx_s;
    logic [IDX_BITS-1:0]       win_idx_s;
    logic [NUM_REQUESTERS-1:0] grant_s;
    logic                      grant_any_s;
    logic                      accept_s;
    logic [REG_ADDR_BITS-1:0]  win_addr_s;
    logic [DATA_WIDTH-1:0]     win_data_s;
    logic [NUM_REGISTERS-1:0]  reserve_dec_s;
    logic [NUM_REGISTERS-1:0]  mask_next_s;
    logic                      stall_s;
    logic                      reserve_take_s;

    logic [NUM_REGISTERS-1:0]  pending_mask_r;
    logic                      port_write_enable_r;
    logic [REG_ADDR_BITS-1:0]  port_write_addr_r;
    logic [DATA_WIDTH-1:0]     port_write_data_r;

    w0rm_core_priority_picker #(
        .NUM_REQ  (NUM_REQUESTERS),
        .IDX_BITS (IDX_BITS)
    ) u_picker (
        .req       (wb.req_valid),
        .start_idx (start_idx_s),
        .grant     (grant_s),
        .grant_idx (win_idx_s),
        .grant_any (grant_any_s)
    );

`ifdef W0RM_RF_ARB_ROUND_ROBIN_EN
    logic [IDX_BITS-1:0] rr_ptr_r;

    // Rotating pointer: moves just past each accepted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            if (int'(win_idx_s) == NUM_REQUESTERS - 1) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= win_idx_s + IDX_BITS'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign start_idx_s = rr_ptr_r;
`else
    assign start_idx_s = '0;
`endif

    // Grant is suppressed during reset so nothing is accepted in that cycle
    always_comb begin
        wb.req_ready = '0;
        accept_s     = 1'b0;
        if (reset) begin
            wb.req_ready = '0;
            accept_s     = 1'b0;
        end else begin
            wb.req_ready = grant_s;
            accept_s     = grant_any_s;
        end
    end

    assign win_addr_s = wb.req_addr[int'(win_idx_s)*REG_ADDR_BITS +: REG_ADDR_BITS];
    assign win_data_s = wb.req_data[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];

    // Reservation check: a same-cycle write to the register frees it, so
    // only an outstanding write that is not being retired now stalls issue
    always_comb begin
        reserve_dec_s  = '0;
        stall_s        = 1'b0;
        reserve_take_s = 1'b0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            reserve_dec_s[r] = (reserve_addr == REG_ADDR_BITS'(r));
        end
        if (reset) begin
            stall_s        = 1'b0;
            reserve_take_s = 1'b0;
        end else begin
            stall_s = reserve_valid
                    & (|(pending_mask_r & reserve_dec_s))
                    & ~(accept_s & (win_addr_s == reserve_addr));
            reserve_take_s = reserve_valid & ~stall_s;
        end
    end

    // Scoreboard next state: clear on accepted write, then set on
    // reservation so a simultaneous clear/set leaves the new owner pending
    always_comb begin
        mask_next_s = '0;
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            mask_next_s[r] = (pending_mask_r[r] & ~(accept_s & (win_addr_s == REG_ADDR_BITS'(r))))
                           | (reserve_take_s & reserve_dec_s[r]);
        end
    end

    // Scoreboard and register-file write port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_mask_r      <= '0;
            port_write_enable_r <= 1'b0;
            port_write_addr_r   <= '0;
            port_write_data_r   <= '0;
        end else begin
            pending_mask_r      <= mask_next_s;
            port_write_enable_r <= accept_s;
            if (accept_s) begin
                port_write_addr_r <= win_addr_s;
                port_write_data_r <= win_data_s;
            end else begin
                port_write_addr_r <= port_write_addr_r;
                port_write_data_r <= port_write_data_r;
            end
        end
    end

    assign reserve_stall     = stall_s;
    assign pending_mask      = pending_mask_r;
    assign port_write_enable = port_write_enable_r;
    assign port_write_addr   = port_write_addr_r;
    assign port_write_data   = port_write_data_r;

endmodule

// File: tb/tb_w0rm_core_regfile_write_arbiter.sv
// Self-checking bench for w0rm_core_regfile_write_arbiter: directed scenarios
// with literal expectations, then randomized traffic compared every cycle
// against a behavioural scoreboard model.
module tb_w0rm_core_regfile_write_arbiter;
    import w0rm_core_pkg::*;

    localparam int N   = 2;
    localparam int NR  = 16;
    localparam int RAB = 4;
    localparam int DW  = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           reserve_valid;
    logic [RAB-1:0] reserve_addr;
    logic           reserve_stall;
    logic [NR-1:0]  pending_mask;
    logic [RAB-1:0] port_write_addr;
    logic           port_write_enable;
    logic [DW-1:0]  port_write_data;

    always #5 clk = ~clk;

    w0rm_core_regfile_write_arbiter_if #(
        .NUM_REQUESTERS (N),
        .REG_ADDR_BITS  (RAB),
        .DATA_WIDTH     (DW)
    ) wb ();

    w0rm_core_regfile_write_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REGISTERS  (NR),
        .NUM_REQUESTERS (N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb                (wb),
        .reserve_valid     (reserve_valid),
        .reserve_addr      (reserve_addr),
        .reserve_stall     (reserve_stall),
        .pending_mask      (pending_mask),
        .port_write_addr   (port_write_addr),
        .port_write_enable (port_write_enable),
        .port_write_data   (port_write_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_mask [NR];
    bit            m_en;
    int            m_addr;
    logic [DW-1:0] m_data;
    int            m_ptr;
    bit            check_en = 1'b0;

    // Which requester should win this cycle (-1 for none)
    function automatic int model_winner();
        int first;
        int i;
        first = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (first < 0 && wb.req_valid[i]) first = i;
            end
        end
        return first;
    endfunction

    function automatic int req_addr_of(input int i);
        return int'(wb.req_addr[i*RAB +: RAB]);
    endfunction

    function automatic bit model_stall(input int w);
        bit freed;
        freed = (w >= 0) && (req_addr_of(w) == int'(reserve_addr));
        return !reset && reserve_valid && m_mask[int'(reserve_addr)] && !freed;
    endfunction

    function automatic logic [NR-1:0] model_mask_vec();
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = m_mask[r];
        return v;
    endfunction

    // Model update at the active edge
    always @(posedge clk) begin
        int w;
        bit st;
        w  = model_winner();
        st = model_stall(w);
        if (reset) begin
            for (int r = 0; r < NR; r++) m_mask[r] = 1'b0;
            m_en = 1'b0; m_addr = 0; m_data = '0; m_ptr = 0;
        end else begin
            if (w >= 0) begin
                m_mask[req_addr_of(w)] = 1'b0;
                m_en   = 1'b1;
                m_addr = req_addr_of(w);
                m_data = wb.req_data[w*DW +: DW];
`ifdef W0RM_RF_ARB_ROUND_ROBIN_EN
                m_ptr  = (w + 1) % N;
`endif
            end else begin
                m_en = 1'b0;
            end
            if (reserve_valid && !st) m_mask[int'(reserve_addr)] = 1'b1;
        end
    end

    // Compare DUT outputs to the model on the falling edge
    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_rdy;
        if (check_en) begin
            w = model_winner();
            exp_rdy = (w < 0) ? '0 : (N'(1) << w);
            check("req_ready", 64'(wb.req_ready), 64'(exp_rdy));
            check("reserve_stall", 64'(reserve_stall), 64'(model_stall(w)));
            check("pending_mask", 64'(pending_mask), 64'(model_mask_vec()));
            check("port_write_enable", 64'(port_write_enable), 64'(m_en));
            check("port_write_addr", 64'(port_write_addr), 64'(m_addr));
            check("port_write_data", 64'(port_write_data), 64'(m_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input logic [DW-1:0] d);
        wb.req_valid[i]          = v;
        wb.req_addr[i*RAB +: RAB] = RAB'(a);
        wb.req_data[i*DW +: DW]   = d;
    endtask

    task automatic idle_inputs();
        wb.req_valid  = '0;
        reserve_valid = 1'b0;
    endtask

    logic [N-1:0]   t3_rdy  [4];
    logic [RAB-1:0] t3_addr [4];

    initial begin
`ifdef W0RM_RF_ARB_ROUND_ROBIN_EN
        t3_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
        t3_addr = '{4'd2, 4'd5, 4'd2, 4'd5};
`else
        t3_rdy  = '{2'b01, 2'b01, 2'b01, 2'b01};
        t3_addr = '{4'd2, 4'd2, 4'd2, 4'd2};
`endif
        // 1: reset with requests and a reservation presented
        reset = 1'b1;
        wb.req_addr = '0;
        wb.req_data = '0;
        set_req(0, 1'b1, 1, 32'h0000_0001);
        set_req(1, 1'b1, 4, 32'h0000_0004);
        reserve_valid = 1'b1;
        reserve_addr  = 4'd6;
        @(negedge clk);
        check("t1_ready_in_reset", 64'(wb.req_ready), 64'(2'b00));
        check("t1_stall_in_reset", 64'(reserve_stall), 64'(1'b0));
        tick();
        check_en = 1'b1;
        @(negedge clk);
        check("t1_ready_in_reset2", 64'(wb.req_ready), 64'(2'b00));
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("t1_enable_after", 64'(port_write_enable), 64'(1'b0));
        check("t1_mask_after", 64'(pending_mask), 64'(16'h0000));

        // 2: single write from requester 0
        tick();
        set_req(0, 1'b1, 3, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t2_ready", 64'(wb.req_ready), 64'(2'b01));
        tick();
        idle_inputs();
        @(negedge clk);
        check("t2_enable", 64'(port_write_enable), 64'(1'b1));
        check("t2_addr", 64'(port_write_addr), 64'(4'd3));
        check("t2_data", 64'(port_write_data), 64'(32'hDEAD_BEEF));
        tick();
        @(negedge clk);
        check("t2_enable_drop", 64'(port_write_enable), 64'(1'b0));
        check("t2_data_hold", 64'(port_write_data), 64'(32'hDEAD_BEEF));

        // 3: both requesters held valid (reset first so the pointer is 0)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 1'b1, 2, 32'h0000_0022);
        set_req(1, 1'b1, 5, 32'h0000_0011);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_grant", 64'(wb.req_ready), 64'(t3_rdy[k]));
            if (k > 0) check("t3_port_addr", 64'(port_write_addr), 64'(t3_addr[k-1]));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("t3_port_addr_last", 64'(port_write_addr), 64'(t3_addr[3]));

        // 4: reservation, repeated reservation, write-and-reserve same cycle
        tick();
        reserve_valid = 1'b1;
        reserve_addr  = 4'd7;
        @(negedge clk);
        check("t4_first_stall", 64'(reserve_stall), 64'(1'b0));
        tick();
        @(negedge clk);
        check("t4_mask_set", 64'(pending_mask), 64'(16'h0080));
        check("t4_stall", 64'(reserve_stall), 64'(1'b1));
        tick();
        @(negedge clk);
        check("t4_mask_unchanged", 64'(pending_mask), 64'(16'h0080));
        set_req(0, 1'b1, 7, 32'h7777_0001);
        #1;
        check("t4_stall_freed", 64'(reserve_stall), 64'(1'b0));
        tick();
        idle_inputs();
        @(negedge clk);
        check("t4_mask_new_owner", 64'(pending_mask), 64'(16'h0080));
        check("t4_write_addr", 64'(port_write_addr), 64'(4'd7));

        // 5: write clears the bit; write to an unreserved register
        tick();
        set_req(0, 1'b1, 7, 32'h7777_0002);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t5_mask_cleared", 64'(pending_mask), 64'(16'h0000));
        check("t5_write_en", 64'(port_write_enable), 64'(1'b1));
        tick();
        set_req(0, 1'b1, 9, 32'h9999_0009);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t5_mask_unreserved", 64'(pending_mask), 64'(16'h0000));
        check("t5_write_data", 64'(port_write_data), 64'(32'h9999_0009));

        // 6: reset wins over a pending write in the same cycle
        tick();
        reserve_valid = 1'b1;
        reserve_addr  = 4'd7;
        tick();
        reserve_valid = 1'b0;
        set_req(0, 1'b1, 7, 32'h6666_0006);
        reset = 1'b1;
        @(negedge clk);
        check("t6_mask_before", 64'(pending_mask), 64'(16'h0080));
        check("t6_ready_in_reset", 64'(wb.req_ready), 64'(2'b00));
        tick();
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("t6_enable", 64'(port_write_enable), 64'(1'b0));
        check("t6_mask", 64'(pending_mask), 64'(16'h0000));

        // Randomized traffic, honouring hold-until-accepted
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] acc;
            @(negedge clk);
            acc = wb.req_valid & wb.req_ready;
            tick();
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) begin
                if (!wb.req_valid[i] || acc[i]) begin
                    set_req(i, ($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)), $urandom());
                end
            end
            reserve_valid = ($urandom_range(0, 1) == 1);
            reserve_addr  = RAB'($urandom_range(0, 7));
        end
        @(negedge clk);
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
